// File: rtl/smu_uart_pkg.sv
// Shared definitions for the memory-mapped 8N1 UART: register offsets,
// STATUS bit positions, FSM encodings and the bit-period helper.
package smu_uart_pkg;

  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_RXDATA = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;

  localparam int ST_TX_BUSY   = 0;
  localparam int ST_RX_VALID  = 1;
  localparam int ST_OVERRUN   = 2;
  localparam int ST_FRAME_ERR = 3;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  function automatic int calc_clks_per_bit(input int clock_freq, input int baud_rate);
    return clock_freq / baud_rate;
  endfunction

endpackage

// File: rtl/smu_uart_rx.sv
// UART receive path: 2-FF input synchronizer and mid-bit sampling FSM.
// Emits the assembled byte with a one-cycle byte_done or frame_err pulse.
module smu_uart_rx
  import smu_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1085
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd_i,
  output logic [7:0] byte_o,
  output logic       byte_done_o,
  output logic       frame_err_o
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       sync_q;
  logic             rxd_s;
  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             done_q, done_d;
  logic             ferr_q, ferr_d;
  logic             stop_hit_s;

  // Idle-high synchronizer so reset never looks like a start bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], rxd_i};
  end

  assign rxd_s = sync_q[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
    end
  end

  // START waits half a bit so every later sample lands mid-bit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        bit_d = 3'd0;
        if (!rxd_s) state_d = RX_START;
        else        state_d = RX_IDLE;
      end
      RX_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          state_d = rxd_s ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      RX_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = {rxd_s, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            bit_d   = 3'd0;
            state_d = RX_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      RX_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = RX_IDLE;
        cnt_d   = '0;
        bit_d   = 3'd0;
      end
    endcase
  end

  assign stop_hit_s = (state_q == RX_STOP) && (cnt_q == CNT_LAST);

  always_comb begin
    done_d = stop_hit_s & rxd_s;
    ferr_d = stop_hit_s & ~rxd_s;
  end

  assign byte_o      = shift_q;
  assign byte_done_o = done_q;
  assign frame_err_o = ferr_q;

endmodule

// File: rtl/smu_uart_mmio.sv
// Memory-mapped 8N1 UART: TX serializer, RX holding register, status flags.
// Read data is combinational for the single-cycle CPU data port.
module smu_uart_mmio
  import smu_uart_pkg::*;
#(
  parameter int CLOCK_FREQ   = 125_000_000,
  parameter int BAUD_RATE    = 115_200,
  parameter int CLKS_PER_BIT = calc_clks_per_bit(CLOCK_FREQ, BAUD_RATE)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs_n,
  input  logic        we,
  input  logic        re,
  input  logic [3:0]  addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  byte_enable,
  output logic [31:0] rdata,
  output logic        uart_txd,
  input  logic        uart_rxd,
  output logic        irq_rx
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sel_s, tx_wr_s, st_wr_s, pop_s, tx_busy_s;
  logic [1:0]       reg_s;
  tx_state_e        tx_state_q, tx_state_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]       tx_bit_q, tx_bit_d;
  logic [7:0]       tx_shift_q, tx_shift_d;
  logic             txd_q, txd_d;
  logic [7:0]       rx_byte_s;
  logic             rx_done_s, rx_ferr_s;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             overrun_q, overrun_d;
  logic             frame_err_q, frame_err_d;
  logic             set_ovr_s;
  logic             unused_s;

  assign sel_s     = ~cs_n;
  assign reg_s     = addr[3:2];
  assign tx_wr_s   = sel_s & we & byte_enable[0] & (reg_s == REG_TXDATA);
  assign st_wr_s   = sel_s & we & byte_enable[0] & (reg_s == REG_STATUS);
  assign pop_s     = sel_s & re & (reg_s == REG_RXDATA);
  assign tx_busy_s = (tx_state_q != TX_IDLE);
  assign unused_s  = ^{addr[1:0], wdata[31:8], byte_enable[3:1]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= 3'd0;
      tx_shift_q <= 8'h00;
      txd_q      <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      txd_q      <= txd_d;
    end
  end

  // Writes outside IDLE are dropped; there is no queue.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    case (tx_state_q)
      TX_IDLE: begin
        if (tx_wr_s) begin
          tx_state_d = TX_START;
          tx_shift_d = wdata[7:0];
          tx_cnt_d   = '0;
          tx_bit_d   = 3'd0;
        end else begin
          tx_state_d = TX_IDLE;
        end
      end
      TX_START: begin
        if (tx_cnt_q == CNT_LAST) begin
          tx_cnt_d   = '0;
          tx_state_d = TX_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_ONE;
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == CNT_LAST) begin
          tx_cnt_d   = '0;
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          if (tx_bit_q == 3'd7) begin
            tx_bit_d   = 3'd0;
            tx_state_d = TX_STOP;
          end else begin
            tx_bit_d = tx_bit_q + 3'd1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_ONE;
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == CNT_LAST) begin
          tx_cnt_d   = '0;
          tx_state_d = TX_IDLE;
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_ONE;
        end
      end
      default: begin
        tx_state_d = TX_IDLE;
        tx_cnt_d   = '0;
        tx_bit_d   = 3'd0;
      end
    endcase
  end

  // Line level follows the upcoming state so the flop output never glitches.
  always_comb begin
    case (tx_state_d)
      TX_START: txd_d = 1'b0;
      TX_DATA:  txd_d = tx_shift_d[0];
      default:  txd_d = 1'b1;
    endcase
  end

  smu_uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk        (clk),
    .reset      (reset),
    .rxd_i      (uart_rxd),
    .byte_o     (rx_byte_s),
    .byte_done_o(rx_done_s),
    .frame_err_o(rx_ferr_s)
  );

  // A pop coinciding with a new byte frees the slot, so the byte is kept.
  always_comb begin
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    set_ovr_s  = 1'b0;
    if (rx_done_s) begin
      if (!rx_valid_q || pop_s) begin
        rx_data_d  = rx_byte_s;
        rx_valid_d = 1'b1;
      end else begin
        set_ovr_s = 1'b1;
      end
    end else if (pop_s) begin
      rx_valid_d = 1'b0;
    end else begin
      rx_valid_d = rx_valid_q;
    end
    overrun_d   = (overrun_q   & ~(st_wr_s & wdata[ST_OVERRUN]))   | set_ovr_s;
    frame_err_d = (frame_err_q & ~(st_wr_s & wdata[ST_FRAME_ERR])) | rx_ferr_s;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    rdata = 32'h0000_0000;
    if (sel_s) begin
      case (reg_s)
        REG_RXDATA: rdata = {24'h00_0000, rx_data_q};
        REG_STATUS: rdata = {28'h000_0000, frame_err_q, overrun_q, rx_valid_q, tx_busy_s};
        default:    rdata = 32'h0000_0000;
      endcase
    end else begin
      rdata = 32'h0000_0000;
    end
  end

  assign uart_txd = txd_q;
  assign irq_rx   = rx_valid_q;

endmodule

// File: tb/tb_smu_uart_mmio.sv
// Directed bench for smu_uart_mmio at 16 clocks per bit.
module tb_smu_uart_mmio;

  logic        clk = 1'b0;
  logic        reset;
  logic        cs_n, we, re;
  logic [3:0]  addr;
  logic [31:0] wdata;
  logic [3:0]  byte_enable;
  logic [31:0] rdata;
  logic        uart_txd;
  logic        uart_rxd;
  logic        irq_rx;

  int n_checks = 0;
  int n_pass   = 0;

  smu_uart_mmio #(
    .CLOCK_FREQ(1600),
    .BAUD_RATE (100)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cs_n       (cs_n),
    .we         (we),
    .re         (re),
    .addr       (addr),
    .wdata      (wdata),
    .byte_enable(byte_enable),
    .rdata      (rdata),
    .uart_txd   (uart_txd),
    .uart_rxd   (uart_rxd),
    .irq_rx     (irq_rx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    cs_n = 1'b0; we = 1'b0; re = 1'b0; addr = a;
    #1;
    d = rdata;
    cs_n = 1'b1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    cs_n = 1'b0; we = 1'b1; re = 1'b0; addr = a; wdata = d; byte_enable = be;
    @(posedge clk); #1;
    we = 1'b0; cs_n = 1'b1; byte_enable = 4'hF;
  endtask

  task automatic pop();
    cs_n = 1'b0; we = 1'b0; re = 1'b1; addr = 4'h4;
    @(posedge clk); #1;
    re = 1'b0; cs_n = 1'b1;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Writes TXDATA then checks the line and busy flag on every one of the 160 frame cycles.
  task automatic tx_frame_check(input logic [7:0] b, input bit inject);
    logic exp_txd;
    int   bi;
    wr(4'h0, {24'h0, b}, 4'hF);
    for (int k = 0; k < 160; k++) begin
      if (inject && k == 50) begin
        cs_n = 1'b0; we = 1'b1; addr = 4'h0; wdata = 32'h0000_00FF;
      end else begin
        cs_n = 1'b0; we = 1'b0; addr = 4'h8;
      end
      #1;
      bi = k / 16;
      if (bi == 0)      exp_txd = 1'b0;
      else if (bi <= 8) exp_txd = b[bi-1];
      else              exp_txd = 1'b1;
      check("tx_line", {31'h0, uart_txd}, {31'h0, exp_txd});
      if (!(inject && k == 50)) check("tx_busy", rdata & 32'h1, 32'h1);
      @(posedge clk); #1;
    end
    we = 1'b0; cs_n = 1'b0; addr = 4'h8;
    #1;
    check("tx_idle_line", {31'h0, uart_txd}, 32'h1);
    check("tx_busy_end", rdata, 32'h0);
    cs_n = 1'b1;
  endtask

  // Drives one 10-bit frame; optionally pops RXDATA during frame cycle pop_c.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int pop_c);
    int bi;
    for (int c = 0; c < 160; c++) begin
      bi = c / 16;
      if (bi == 0)      uart_rxd = 1'b0;
      else if (bi <= 8) uart_rxd = b[bi-1];
      else              uart_rxd = stop;
      if (c == pop_c) begin
        cs_n = 1'b0; re = 1'b1; addr = 4'h4;
      end else if (c == pop_c + 1) begin
        re = 1'b0; cs_n = 1'b1;
      end
      @(posedge clk); #1;
    end
    uart_rxd = 1'b1;
  endtask

  logic [31:0] v;

  initial begin
    reset = 1'b1; cs_n = 1'b1; we = 1'b0; re = 1'b0; addr = 4'h0;
    wdata = 32'h0; byte_enable = 4'hF; uart_rxd = 1'b1;
    cycles(3);
    reset = 1'b0;
    cycles(2);
    check("rst_txd", {31'h0, uart_txd}, 32'h1);
    check("rst_irq", {31'h0, irq_rx}, 32'h0);
    rd(4'h8, v); check("rst_status", v, 32'h0);

    tx_frame_check(8'h55, 1'b1);

    send_frame(8'hA5, 1'b1, -10);
    rd(4'h8, v); check("rx_status", v, 32'h2);
    check("rx_irq", {31'h0, irq_rx}, 32'h1);
    rd(4'h4, v); check("rx_data", v, 32'hA5);
    addr = 4'h8; cs_n = 1'b1; #1; check("rdata_no_cs", rdata, 32'h0);
    rd(4'h0, v); check("txdata_reads_0", v, 32'h0);
    rd(4'hC, v); check("reserved_reads_0", v, 32'h0);
    pop();
    rd(4'h8, v); check("pop_status", v, 32'h0);
    check("pop_irq", {31'h0, irq_rx}, 32'h0);

    send_frame(8'h11, 1'b1, -10);
    send_frame(8'h22, 1'b1, -10);
    rd(4'h4, v); check("ovr_data", v, 32'h11);
    rd(4'h8, v); check("ovr_status", v, 32'h6);
    wr(4'h8, 32'h4, 4'h0);
    rd(4'h8, v); check("w1c_no_be", v, 32'h6);
    wr(4'h8, 32'h4, 4'h1);
    rd(4'h8, v); check("w1c_ovr", v, 32'h2);
    send_frame(8'h22, 1'b1, 155);
    rd(4'h4, v); check("pop_load_data", v, 32'h22);
    rd(4'h8, v); check("pop_load_status", v, 32'h2);
    pop();
    rd(4'h8, v); check("pop2_status", v, 32'h0);

    uart_rxd = 1'b0;
    cycles(4);
    uart_rxd = 1'b1;
    cycles(30);
    rd(4'h8, v); check("glitch_status", v, 32'h0);
    check("glitch_irq", {31'h0, irq_rx}, 32'h0);

    send_frame(8'h3C, 1'b0, -10);
    cycles(20);
    rd(4'h8, v); check("ferr_status", v, 32'h8);
    check("ferr_irq", {31'h0, irq_rx}, 32'h0);
    wr(4'h8, 32'h8, 4'h1);
    rd(4'h8, v); check("w1c_ferr", v, 32'h0);

    wr(4'h0, 32'h0F, 4'hF);
    cycles(84);
    check("mid_tx_bit4", {31'h0, uart_txd}, 32'h0);
    rd(4'h8, v); check("mid_tx_busy", v, 32'h1);
    reset = 1'b1;
    #1;
    check("rst_async_txd", {31'h0, uart_txd}, 32'h1);
    rd(4'h8, v); check("rst_async_status", v, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    cycles(1);
    tx_frame_check(8'hC3, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/smu_uart_mmio.md
Name: smu_uart_mmio

Overview:
Memory-mapped 8N1 UART peripheral on the RV32I data bus, downstream of the CPU data port alongside the data RAM. It is selected by the system address decoder's cs_uart_n and drives the board pins UART_TXD/UART_RXD. It provides a TX serializer, an RX deserializer with a one-byte holding register, and status/error flags. Read data is combinational, to suit the single-cycle CPU.

Parameters:
CLOCK_FREQ, 125_000_000, core clock in Hz.
BAUD_RATE, 115_200, line rate in baud.
CLKS_PER_BIT, CLOCK_FREQ/BAUD_RATE, clocks per bit (integer divide); must be >= 4. Default value is 1085.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
cs_n  in  1  chip select, active low
we  in  1  write strobe, qualified by cs_n
re  in  1  read strobe, qualified by cs_n; pops RX on the clock edge
addr  in  4  byte address; only [3:2] decoded
wdata  in  32  write data
byte_enable  in  4  write byte lanes
rdata  out  32  combinational read data; 0 when cs_n=1
uart_txd  out  1  serial out; idle high
uart_rxd  in  1  serial in; asynchronous to clk
irq_rx  out  1  level, equals rx_valid

Behaviour:
- Reset (async, active-high): uart_txd=1, tx_busy=0, rx_valid=0, overrun=0, frame_err=0, rx_data=0, both FSMs IDLE, RX synchronizer flops=1, irq_rx=0.
- Register map (addr[3:2]):
  - 0 TXDATA: write-only, uses wdata[7:0] with byte_enable[0]; reads return 0.
  - 1 RXDATA: read gives {24'b0, rx_data}; a read with re=1 clears rx_valid on that edge.
  - 2 STATUS: bit0 tx_busy, bit1 rx_valid, bit2 overrun, bit3 frame_err, other bits 0. Writes with byte_enable[0] clear bits 2 and 3 where wdata has a 1 (W1C).
  - 3: reserved; reads 0, writes ignored.
- TX FSM: IDLE -> START -> DATA(8) -> STOP -> IDLE.
  - A TXDATA write in IDLE latches the byte; tx_busy=1 from the next cycle.
  - The start bit drives on the cycle after the write.
  - Each bit holds exactly CLKS_PER_BIT cycles; data is sent LSB first; stop bit is 1.
  - tx_busy falls after the last stop cycle, giving 10*CLKS_PER_BIT busy cycles in total.
  - A TXDATA write while tx_busy=1 is ignored: no queueing, no flag.
  - uart_txd is registered (glitch-free).
- RX path: uart_rxd passes through a 2-FF synchronizer; all decisions use the synchronized bit (2-cycle input latency).
- RX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: a synchronized 0 enters START and counts CLKS_PER_BIT/2 cycles.
  - START: if the line is 0 at mid-bit, go to DATA; if 1, treat as a glitch and return to IDLE with no flags.
  - DATA: sample every CLKS_PER_BIT cycles into a shift register, 8 bits, LSB first.
  - STOP: sample at mid-stop.
    - Sample 1 and rx_valid=0: load rx_data, set rx_valid.
    - Sample 1 and rx_valid=1: discard the new byte, set overrun.
    - Sample 0: discard the byte, set frame_err.
  - Return to IDLE right after the mid-stop sample. The line is high there, so no false start.
- Simultaneous events:
  - An RXDATA pop in the same cycle as a stop-bit load stores the new byte, keeps rx_valid=1, and does not set overrun.
  - A W1C in the same cycle as a new error: set wins.
- Assertion of reset at any point aborts any in-flight frame immediately; uart_txd returns to 1 asynchronously.
- Bit counters are sized ceil(log2(CLKS_PER_BIT)) and wrap only through an explicit reload, never by overflow.

Decomposition:
- Package smu_uart_pkg holds:
  - register offsets (TXDATA=0, RXDATA=1, STATUS=2);
  - STATUS bit indices;
  - TX/RX state encodings;
  - the CLKS_PER_BIT helper function.
- One sub-module, smu_uart_rx (synchronizer plus RX FSM), outputs a byte, a byte_done pulse and a frame_err pulse. TX, registers and flags stay in the top level.

Test Plan:
- Set CLKS_PER_BIT=16 (CLOCK_FREQ=1600, BAUD_RATE=100) for all scenarios.
- Reset: assert reset mid-run -> uart_txd=1, STATUS reads 0x0, irq_rx=0, and rdata=0 with cs_n=1.
- TX 0x55: write TXDATA=0x55 -> from the next cycle uart_txd is 0 for 16 cycles, then 1,0,1,0,1,0,1,0 at 16 cycles each, then stop 1. STATUS bit0=1 for exactly 160 cycles, then 0. A second write of 0xFF at cycle 50 of the frame changes nothing.
- RX 0xA5: drive a valid frame -> a few cycles after mid-stop, STATUS=0x2 and irq_rx=1, RXDATA reads 0xA5. After the re pop, STATUS=0x0.
- Overrun: send 0x11 then 0x22 without reading -> RXDATA=0x11, STATUS=0x6. Writing 0x4 to STATUS gives 0x2. A pop issued on the exact 0x22 load cycle instead gives RXDATA=0x22 and no overrun.
- Errors: an rxd low pulse of 4 cycles -> no state change. A frame 0x3C with stop=0 -> STATUS=0x8 and rx_valid=0. Writing 0x8 to STATUS -> 0x0.
- Reset mid-TX: reset at bit 4 of a TX frame -> uart_txd=1 immediately, tx_busy=0. After release, a new TXDATA write starts a clean frame.
